// File: rtl/audio_sample_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared types and constants for the HDMI audio sample scheduler.
//   CHANNEL_STATUS_LENGTH   frames in one IEC 60958 channel-status block
//   MAX_SAMPLES_PER_PACKET  sample pairs carried by one audio sample packet
//   audio_pair_t            one stereo pair, each sample MSB-aligned in 24 bits
//   sched_state_t           scheduler FSM states
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam logic [7:0] CHANNEL_STATUS_LENGTH  = 8'd192;
    localparam int         MAX_SAMPLES_PER_PACKET = 4;
    localparam int         WORD_WIDTH             = 24;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] right;
        logic [WORD_WIDTH-1:0] left;
    } audio_pair_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/audio_sample_scheduler_if.sv
// -----------------------------------------------------------------------------
// audio_sample_scheduler_if
// Groups the sample input, packet-slot request and packet output of the
// scheduler.
//   master : sample source / packet picker side (drives samples and requests)
//   slave  : scheduler side (drives packet contents and status)
// Signals:
//   sample_valid, sample_left, sample_right   one-cycle L/R pair strobe
//   packet_req                                picker offers a packet slot
//   packet_valid                              one-cycle packet strobe
//   frame_counter                             IEC 60958 frame index of lane 0
//   audio_sample_word                         [lane][0]=L, [lane][1]=R, 24-bit
//   audio_sample_word_present                 lanes carrying data
//   fifo_level, overflow                      occupancy and sticky drop flag
// -----------------------------------------------------------------------------
interface audio_sample_scheduler_if #(
    parameter int AUDIO_BIT_WIDTH = 24,
    parameter int FIFO_DEPTH      = 8
);
    logic                         sample_valid;
    logic [AUDIO_BIT_WIDTH-1:0]   sample_left;
    logic [AUDIO_BIT_WIDTH-1:0]   sample_right;
    logic                         packet_req;

    logic                         packet_valid;
    logic [7:0]                   frame_counter;
    logic [3:0][1:0][23:0]        audio_sample_word;
    logic [3:0]                   audio_sample_word_present;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;
    logic                         overflow;

    modport master (
        output sample_valid, sample_left, sample_right, packet_req,
        input  packet_valid, frame_counter, audio_sample_word,
               audio_sample_word_present, fifo_level, overflow
    );

    modport slave (
        input  sample_valid, sample_left, sample_right, packet_req,
        output packet_valid, frame_counter, audio_sample_word,
               audio_sample_word_present, fifo_level, overflow
    );
endinterface

// File: rtl/audio_sample_scheduler_fifo.sv
// -----------------------------------------------------------------------------
// audio_sample_fifo
// Register-array FIFO of stereo pairs with one write port and a four-entry
// combinational head window, so a whole packet can be popped in one cycle.
//   clk_pixel   clock
//   reset       synchronous active-high reset
//   i_flush     empty the FIFO on the next edge (overrides push/pop)
//   i_push      write i_push_data at the tail
//   i_push_data pair to write
//   i_pop_n     number of entries to drop from the head, 0..4
//   o_head      head window, o_head[0] is the oldest entry
//   o_level     current occupancy
// -----------------------------------------------------------------------------
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic                 clk_pixel,
    input  logic                 reset,
    input  logic                 i_flush,
    input  logic                 i_push,
    input  audio_pair_t          i_push_data,
    input  logic [2:0]           i_pop_n,
    output audio_pair_t [3:0]    o_head,
    output logic [LVL_W-1:0]     o_level
);

    audio_pair_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // NOTE: storage is not reset; entries are only ever read after being
    // written, and leaving it out of reset keeps it a plain register array.
    always_ff @(posedge clk_pixel) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_pixel) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_n);
            r_level  <= r_level + LVL_W'(i_push) - LVL_W'(i_pop_n);
        end
    end

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    for (genvar k = 0; k < MAX_SAMPLES_PER_PACKET; k++) begin : g_head
        assign o_head[k] = r_mem[r_rd_ptr + PTR_W'(k)];
    end

    assign o_level = r_level;

endmodule

// File: rtl/audio_sample_scheduler.sv
// -----------------------------------------------------------------------------
// audio_sample_scheduler
// Buffers stereo sample pairs and, on each audio packet slot offered by the
// packet picker, pops up to four pairs into the registered sample array used
// by the HDMI audio sample packet encoder. Tracks the position within the
// 192-frame IEC 60958 channel-status block.
//   clk_pixel   pixel clock, sole clock
//   reset       synchronous active-high reset
//   enable      0 = flush FIFO, refuse samples, emit no packets
//   bus         audio_sample_scheduler_if slave: samples in, packets out
// -----------------------------------------------------------------------------
module audio_sample_scheduler
    import audio_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 24,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                      clk_pixel,
    input  logic                      reset,
    input  logic                      enable,
    audio_sample_scheduler_if.slave   bus
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PAD_W = WORD_WIDTH - AUDIO_BIT_WIDTH;

    sched_state_t          r_state;
    sched_state_t          w_state_next;
    logic                  w_flush;

    logic [LVL_W-1:0]      w_level;
    logic [2:0]            w_pop_n;
    logic                  w_space;
    logic                  w_push;
    audio_pair_t           w_push_pair;
    audio_pair_t [3:0]     w_head;

    logic [7:0]            r_pos;
    logic [8:0]            w_pos_sum;
    logic [7:0]            w_pos_next;

    logic                  r_packet_valid;
    logic [7:0]            r_frame_counter;
    logic [3:0][1:0][23:0] r_word;
    logic [3:0]            r_present;
    logic                  r_overflow;

    // ---------------- FSM ----------------
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_flush      = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_next = RUN;
                else        w_flush      = 1'b1;
            end
            RUN: begin
                if (!enable) begin
                    w_state_next = IDLE;
                    w_flush      = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ---------------- Pop / push decisions ----------------
    // Pop count uses the level before this cycle's push; a request while
    // enable is low is ignored.
    always_comb begin
        w_pop_n = '0;
        if (enable && bus.packet_req) begin
            w_pop_n = (w_level >= LVL_W'(MAX_SAMPLES_PER_PACKET)) ? 3'd4 : w_level[2:0];
        end
    end

    // Space is judged after the pop, so a full FIFO still takes a push
    // alongside a non-empty pop.
    assign w_space = (w_level - LVL_W'(w_pop_n)) < LVL_W'(FIFO_DEPTH);
    assign w_push  = enable && bus.sample_valid && w_space;

    // MSB-align each sample into a 24-bit word.
    assign w_push_pair.left  = WORD_WIDTH'(bus.sample_left)  << PAD_W;
    assign w_push_pair.right = WORD_WIDTH'(bus.sample_right) << PAD_W;

    audio_sample_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_pixel   (clk_pixel),
        .reset       (reset),
        .i_flush     (w_flush),
        .i_push      (w_push),
        .i_push_data (w_push_pair),
        .i_pop_n     (w_pop_n),
        .o_head      (w_head),
        .o_level     (w_level)
    );

    // ---------------- Channel-status block position ----------------
    assign w_pos_sum  = {1'b0, r_pos} + 9'(w_pop_n);
    assign w_pos_next = (w_pos_sum >= 9'(CHANNEL_STATUS_LENGTH))
                      ? 8'(w_pos_sum - 9'(CHANNEL_STATUS_LENGTH))
                      : w_pos_sum[7:0];

    // ---------------- Output registers ----------------
    // Packet contents hold until the next packet; only packet_valid pulses.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_pos           <= '0;
            r_packet_valid  <= 1'b0;
            r_frame_counter <= '0;
            r_word          <= '0;
            r_present       <= '0;
            r_overflow      <= 1'b0;
        end else begin
            r_packet_valid <= 1'b0;
            r_pos          <= w_flush ? 8'd0 : w_pos_next;

            if (w_pop_n != 3'd0) begin
                r_packet_valid  <= 1'b1;
                r_frame_counter <= r_pos;
                for (int i = 0; i < MAX_SAMPLES_PER_PACKET; i++) begin
                    r_present[i]  <= (3'(i) < w_pop_n);
                    r_word[i][0]  <= (3'(i) < w_pop_n) ? w_head[i].left  : 24'd0;
                    r_word[i][1]  <= (3'(i) < w_pop_n) ? w_head[i].right : 24'd0;
                end
            end

            if (enable && bus.sample_valid && !w_space) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.packet_valid              = r_packet_valid;
    assign bus.frame_counter             = r_frame_counter;
    assign bus.audio_sample_word         = r_word;
    assign bus.audio_sample_word_present = r_present;
    assign bus.fifo_level                = w_level;
    assign bus.overflow                  = r_overflow;

endmodule
